// File: rtl/scaler_step_ctrl.sv
// rtl/scaler_step_ctrl.sv - computes the (4.12) horizontal scale step with a bit-serial divider
// and commits it to the scaler only on a vertical-sync rising edge.
module scaler_step_ctrl #(
  parameter int          WIDTH_BITS = 12,
  parameter logic [15:0] INIT_STEP  = 16'd4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [WIDTH_BITS-1:0] cfg_in_w,
  input  logic [WIDTH_BITS-1:0] cfg_out_w,
  input  logic                  vs_i,
  output logic [15:0]           scale_step,
  output logic                  step_upd,
  output logic                  cfg_busy,
  output logic                  pend_vld,
  output logic                  cfg_err
);

  localparam int DW = WIDTH_BITS + 12;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         dvd;
  logic [WIDTH_BITS-1:0] dvs;
  logic [WIDTH_BITS:0]   rem, rem_sh;
  logic [CW-1:0]         cnt;
  logic [15:0]           pending;
  logic                  vs_q;
  logic                  accept, reject, done, commit, q_bit, ovf;

  // dividend register doubles as the quotient register: quotient bits shift in at the LSB
  assign rem_sh   = {rem[WIDTH_BITS-1:0], dvd[DW-1]};
  assign q_bit    = (rem_sh >= {1'b0, dvs});
  assign done     = (state == DONE);
  assign ovf      = |dvd[DW-1:16];
  assign commit   = vs_i & ~vs_q & pend_vld;
  assign cfg_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_wr) begin
          if ((cfg_in_w == '0) || (cfg_out_w == '0)) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = DIV;
          end
        end
      end
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cnt        <= '0;
      pending    <= '0;
      pend_vld   <= 1'b0;
      scale_step <= INIT_STEP;
      step_upd   <= 1'b0;
      cfg_err    <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      vs_q     <= vs_i;
      step_upd <= commit;
      if (accept) begin
        dvd     <= {cfg_in_w, 12'b0};
        dvs     <= cfg_out_w;
        rem     <= '0;
        cnt     <= CW'(DW - 1);
        cfg_err <= 1'b0;
      end
      if (reject) cfg_err <= 1'b1;
      if (state == DIV) begin
        rem <= q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
        dvd <= {dvd[DW-2:0], q_bit};
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        pending <= ovf ? 16'hFFFF : dvd[15:0];
        if (ovf) cfg_err <= 1'b1;
      end
      // commit reads the pre-edge pending value; a same-edge DONE keeps its result pending
      if (commit) scale_step <= pending;
      pend_vld <= done | (pend_vld & ~commit);
    end
  end

endmodule

// File: tb/tb_scaler_step_ctrl.sv
// tb/tb_scaler_step_ctrl.sv - directed and randomized checks of scaler_step_ctrl against
// an arithmetic model of the step computation and frame-boundary commit.
module tb_scaler_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [11:0] cfg_in_w, cfg_out_w;
  logic        vs_i;
  logic [15:0] scale_step;
  logic        step_upd, cfg_busy, pend_vld, cfg_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_step;
  logic [15:0] m_pend;
  logic        m_pend_vld;
  logic        m_err;

  scaler_step_ctrl #(.WIDTH_BITS(12), .INIT_STEP(16'd4096)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_in_w(cfg_in_w), .cfg_out_w(cfg_out_w),
    .vs_i(vs_i), .scale_step(scale_step), .step_upd(step_upd), .cfg_busy(cfg_busy),
    .pend_vld(pend_vld), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_div(input int in_w, input int out_w);
    longint q;
    q = (longint'(in_w) * 4096) / longint'(out_w);
    if (q > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(q)};
  endfunction

  task automatic wait_idle(input string tag, input int exp_len);
    int n = 0;
    while (cfg_busy === 1'b1 && n < 100) begin
      n++;
      cycle();
    end
    check({tag, "_busy_len"}, n, exp_len);
  endtask

  task automatic do_cfg(input string tag, input int in_w, input int out_w);
    logic [16:0] r;
    cfg_in_w  = 12'(in_w);
    cfg_out_w = 12'(out_w);
    cfg_wr    = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    if (in_w == 0 || out_w == 0) begin
      m_err = 1'b1;
      check({tag, "_zero_busy"}, cfg_busy, 0);
      check({tag, "_zero_pend"}, pend_vld, m_pend_vld);
    end else begin
      r = model_div(in_w, out_w);
      wait_idle(tag, 25);
      m_pend     = r[15:0];
      m_pend_vld = 1'b1;
      m_err      = r[16];
      check({tag, "_pend_vld"}, pend_vld, 1);
    end
    check({tag, "_err"}, cfg_err, m_err);
  endtask

  task automatic vsync(input string tag);
    logic exp_upd;
    exp_upd = m_pend_vld;
    if (m_pend_vld) begin
      m_step     = m_pend;
      m_pend_vld = 1'b0;
    end
    vs_i = 1'b1;
    cycle();
    check({tag, "_upd"}, step_upd, exp_upd);
    check({tag, "_step"}, scale_step, m_step);
    check({tag, "_pend_clr"}, pend_vld, 0);
    cycle();
    check({tag, "_upd_width"}, step_upd, 0);
    vs_i = 1'b0;
    cycle();
  endtask

  task automatic model_reset();
    m_step     = 16'd4096;
    m_pend     = '0;
    m_pend_vld = 1'b0;
    m_err      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_in_w = '0; cfg_out_w = '0; vs_i = 1'b0;
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("rst_step", scale_step, 4096);
    check("rst_upd", step_upd, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_pend", pend_vld, 0);
    check("rst_err", cfg_err, 0);

    do_cfg("c1920_1280", 1920, 1280);
    vsync("v1920_1280");
    check("v1920_1280_val", scale_step, 16'h1800);

    do_cfg("c1280_1920", 1280, 1920);
    vsync("v1280_1920");
    check("v1280_1920_val", scale_step, 2730);

    do_cfg("c_ovf", 4095, 1);
    vsync("v_ovf");
    check("ovf_val", scale_step, 16'hFFFF);
    check("ovf_err", cfg_err, 1);

    do_cfg("c_zero", 1920, 0);
    vsync("v_zero");

    do_cfg("c_ow1", 1920, 1280);
    do_cfg("c_ow2", 1920, 960);
    vsync("v_ow");
    check("ow_val", scale_step, 8192);
    vsync("v_ow_again");

    cfg_in_w = 12'd1920; cfg_out_w = 12'd1280; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    repeat (5) cycle();
    cfg_in_w = 12'd100; cfg_out_w = 12'd50; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    wait_idle("ignored", 19);
    m_pend = 16'd6144; m_pend_vld = 1'b1; m_err = 1'b0;
    check("ignored_err", cfg_err, 0);
    vsync("v_ignored");

    do_cfg("c_pre_rst", 1280, 1920);
    vsync("v_pre_rst");
    cfg_in_w = 12'd1920; cfg_out_w = 12'd960; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    check("midrst_step", scale_step, 4096);
    check("midrst_busy", cfg_busy, 0);
    check("midrst_pend", pend_vld, 0);
    repeat (30) cycle();
    check("midrst_pend_late", pend_vld, 0);
    vsync("v_midrst");

    cfg_in_w = 12'd1280; cfg_out_w = 12'd1920; cfg_wr = 1'b1;
    cycle();
    cfg_wr = 1'b0;
    repeat (24) cycle();
    check("coinc_busy_before", cfg_busy, 1);
    vs_i = 1'b1;
    cycle();
    check("coinc_step", scale_step, 4096);
    check("coinc_upd", step_upd, 0);
    check("coinc_pend", pend_vld, 1);
    vs_i = 1'b0;
    cycle();
    m_pend = 16'd2730; m_pend_vld = 1'b1;
    vsync("v_coinc");

    for (int i = 0; i < 8; i++) begin
      int a, b;
      a = int'($urandom_range(1, 4095));
      b = int'($urandom_range(1, 4095));
      if (i == 7) b = int'($urandom_range(1, 3));
      do_cfg("c_rand", a, b);
      vsync("v_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scaler_step_ctrl.md
# scaler_step_ctrl

Configuration controller for the horizontal scaler datapath. It accepts an input/output line-width pair from the register interface and computes the (4.12) unsigned fixed-point `scale_step = floor(in_w * 4096 / out_w)` with a bit-serial restoring divider. It holds the result in a pending register and commits it to the scaler's `scale_step` input only on a frame boundary, so a step change never lands mid-frame. It sits between the control-register block and the `scale_step` port of the horizontal scaler.

## Interface
- `WIDTH_BITS`, default 12: width of `cfg_in_w` and `cfg_out_w`.
- `INIT_STEP`, default 4096: reset value of `scale_step` (1.000).
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_wr`  in  1  one-cycle strobe; samples `cfg_in_w` and `cfg_out_w`.
- `cfg_in_w`  in  WIDTH_BITS  input line width, in pixels.
- `cfg_out_w`  in  WIDTH_BITS  output line width, in pixels.
- `vs_i`  in  1  vertical sync, same stream as the scaler input; active-high.
- `scale_step`  out  16  committed step, (4.12); reset value `INIT_STEP`.
- `step_upd`  out  1  one-cycle pulse in the cycle `scale_step` changes; reset 0.
- `cfg_busy`  out  1  divider running; reset 0.
- `pend_vld`  out  1  a computed step is waiting for a frame boundary; reset 0.
- `cfg_err`  out  1  sticky error flag for the last accepted `cfg_wr`; reset 0.

## Operation
- States are IDLE, DIV and DONE.
- **IDLE**
  - If `cfg_wr=1`, the block checks the widths first.
  - If `cfg_out_w==0` or `cfg_in_w==0`: set `cfg_err=1`, stay in IDLE, and leave the pending register, `pend_vld` and `scale_step` untouched.
  - Otherwise: clear `cfg_err`, load dividend `{cfg_in_w, 12'b0}` (WIDTH_BITS+12 bits), load divisor `cfg_out_w`, clear the remainder, set the bit counter to WIDTH_BITS+11, and go to DIV.
- **DIV**
  - Each cycle runs one restoring step, MSB first:
    - `rem = {rem, dividend_msb}`;
    - if `rem >= divisor`, subtract the divisor and shift in quotient bit 1, else shift in 0.
  - The remainder register is WIDTH_BITS+1 bits.
  - After WIDTH_BITS+12 steps, go to DONE.
- **DONE**
  - If quotient > 16'hFFFF: pending = 16'hFFFF and `cfg_err=1`.
  - Otherwise: pending = quotient[15:0].
  - Set `pend_vld=1` and return to IDLE.
- **Overwrite:** a newer DONE overwrites an uncommitted pending value. The newest value wins, and no intermediate value is ever committed.
- **Commit**
  - A frame boundary is the rising edge of `vs_i`: `vs_i=1` and the registered `vs_i` was 0.
  - At a boundary with `pend_vld=1`: `scale_step <= pending`, `pend_vld <= 0`, and `step_upd` pulses.
  - If `pend_vld=0` at the boundary, nothing happens.
- **Divider busy:** `cfg_wr` while `cfg_busy=1` is ignored (no queueing, no error). The master must poll `cfg_busy`.
- **Reset mid-operation:** every register returns to its reset value, the in-flight division and the pending value are discarded, and `scale_step` returns to `INIT_STEP`.

## Timing
- **Accepted `cfg_wr` at edge T:**
  - `cfg_busy=1` after edges T … T+WIDTH_BITS+12 (25 cycles at default).
  - `cfg_busy=0` and `pend_vld=1` after edge T+WIDTH_BITS+13 (T+25 at default).
- **Error cases:** `cfg_err` updates after edge T for a zero width, or after the DONE edge for overflow.
- **Commit latency:** `scale_step` and `step_upd` update at the edge following the rising edge of `vs_i` being present on the input, i.e. 1 cycle after `vs_i` rises.
- **DONE and commit in the same cycle:** the commit uses the pending value registered before that edge. If `pend_vld` was 0 before the edge, the new result waits for the next frame.
- **`cfg_wr` and `vs_i` rise in the same cycle:** both act independently.
- **`step_upd` pulse width:** exactly 1 cycle, even if `vs_i` stays high.
- **Commit and scaler counters:** `scale_step` is stable for the whole frame. A commit on the `vs_i` rising edge coincides with the scaler's counter reset, so the new step applies from the first line of the new frame.

## Test plan
- 1920→1280:
  - `cfg_wr` with in=1920, out=1280 → `cfg_busy` high for 25 cycles, then `pend_vld=1`.
  - Next `vs_i` rise → `scale_step=6144` (0x1800), one `step_upd` pulse, `cfg_err=0`.
- 1280→1920 → `scale_step=2730` (truncation of 2730.67).
- Overflow and zero width:
  - in=4095, out=1 → `scale_step=16'hFFFF` after commit, `cfg_err=1`.
  - Then out=0 → `cfg_err` stays 1, `scale_step` stays 16'hFFFF, no `pend_vld`.
- Overwrite and ignored write:
  - Two configs (1920/1280, then 1920/960) complete before any `vs_i` → the commit yields 8192, with only one `step_upd`.
  - `cfg_wr` during `cfg_busy` → ignored, and the result equals the first config.
- Reset mid-division:
  - Assert `rst` at cycle 10 of DIV → `scale_step=4096`, `cfg_busy=0`, `pend_vld=0`.
  - The next `vs_i` rise produces no `step_upd`.
- DONE in the same cycle as a `vs_i` rise → `scale_step` is unchanged at that edge and updates on the following `vs_i` rise.
